// File: rtl/spram_arbiter_if.sv
// spram_arbiter_if: CPU and DMA request ports plus the shared SPRAM bus.
interface spram_arbiter_if;
  logic        cpu_valid, cpu_write, cpu_stall;
  logic [3:0]  cpu_wmask;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic [13:0] cpu_addr;
  logic        dma_req, dma_write, dma_ack, dma_rvalid;
  logic [3:0]  dma_wmask;
  logic [31:0] dma_wdata, dma_rdata;
  logic [13:0] dma_addr;
  logic        ram_write, ram_standby;
  logic [3:0]  ram_wmask;
  logic [31:0] ram_wdata, ram_rdata;
  logic [13:0] ram_addr;
  modport master (
    output cpu_valid, cpu_write, cpu_wmask, cpu_wdata, cpu_addr,
    output dma_req, dma_write, dma_wmask, dma_wdata, dma_addr, ram_rdata,
    input  cpu_rdata, cpu_stall, dma_ack, dma_rvalid, dma_rdata,
    input  ram_write, ram_wmask, ram_wdata, ram_addr, ram_standby
  );
  modport slave (
    input  cpu_valid, cpu_write, cpu_wmask, cpu_wdata, cpu_addr,
    input  dma_req, dma_write, dma_wmask, dma_wdata, dma_addr, ram_rdata,
    output cpu_rdata, cpu_stall, dma_ack, dma_rvalid, dma_rdata,
    output ram_write, ram_wmask, ram_wdata, ram_addr, ram_standby
  );
endinterface

// File: rtl/spram_arbiter.sv
// spram_arbiter: CPU/DMA arbiter for one SPRAM with a DMA starvation guard.
// Define SPRAM_STANDBY_EN to drop the SPRAM into standby after IDLE_CYCLES idle cycles.
module spram_arbiter #(
  parameter int MAX_WAIT    = 8,
  parameter int IDLE_CYCLES = 64
) (
  input logic            clk,
  input logic            rst,
  spram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {ACTIVE, FORCE, STANDBY, WAKE} state_t;
  state_t     state;
  logic [3:0] wait_cnt;
  logic       grant_cpu, grant_dma, dma_wait, wake, force_hit, idle_hit, ram_write;
  if (MAX_WAIT < 2 || MAX_WAIT > 15 || IDLE_CYCLES < 2 || IDLE_CYCLES > 255) begin : g_bad_param
    $error("spram_arbiter: MAX_WAIT or IDLE_CYCLES out of range");
  end
  always_comb begin
    grant_cpu = !rst && state == ACTIVE && bus.cpu_valid;
    grant_dma = !rst && bus.dma_req && (state == FORCE || (state == ACTIVE && !bus.cpu_valid));
    dma_wait  = bus.dma_req && !grant_dma;
    wake      = bus.cpu_valid || bus.dma_req;
    force_hit = state == ACTIVE && dma_wait && {1'b0, wait_cnt} + 5'd1 >= 5'(MAX_WAIT);
    ram_write = grant_cpu ? bus.cpu_write : grant_dma && bus.dma_write;
  end
  assign bus.dma_ack   = grant_dma;
  assign bus.cpu_stall = !rst && (state == FORCE || ((state == STANDBY || state == WAKE) && bus.cpu_valid));
  assign bus.ram_write = ram_write;
  assign bus.ram_wmask = !ram_write ? 4'h0 : grant_cpu ? bus.cpu_wmask : bus.dma_wmask;
  assign bus.ram_addr  = grant_cpu ? bus.cpu_addr : bus.dma_addr;
  assign bus.ram_wdata = grant_cpu ? bus.cpu_wdata : bus.dma_wdata;
  assign bus.cpu_rdata = bus.ram_rdata;
  assign bus.dma_rdata = bus.ram_rdata;
`ifdef SPRAM_STANDBY_EN
  logic [7:0] idle_cnt;
  assign idle_hit        = state == ACTIVE && !wake && {1'b0, idle_cnt} + 9'd1 >= 9'(IDLE_CYCLES);
  assign bus.ram_standby = !rst && state == STANDBY;
  always_ff @(posedge clk)
    idle_cnt <= rst || state != ACTIVE || wake || idle_hit ? 8'd0 : idle_cnt + 8'd1;
`else
  assign idle_hit        = 1'b0;
  assign bus.ram_standby = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ACTIVE;
      wait_cnt       <= 4'd0;
      bus.dma_rvalid <= 1'b0;
    end else begin
      wait_cnt       <= !dma_wait ? 4'd0 : &wait_cnt ? wait_cnt : wait_cnt + 4'd1;
      bus.dma_rvalid <= grant_dma && !bus.dma_write;
      case (state)
        ACTIVE:  state <= force_hit ? FORCE : idle_hit ? STANDBY : ACTIVE;
        STANDBY: state <= wake ? WAKE : STANDBY;
        default: state <= ACTIVE;
      endcase
    end
  end
endmodule

// File: doc/spram_arbiter.md
SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 8: DMA starvation limit in cycles (2..15).
REQ-002 SHALL have parameter IDLE_CYCLES, default 64: idle cycles before standby (2..255).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have ports cpu_valid/cpu_write  input  1/1  CPU request, write qualifier.
REQ-006 SHALL have ports cpu_wmask/cpu_wdata/cpu_addr  input  4/32/14  CPU byte mask, data, word address.
REQ-007 SHALL have ports cpu_rdata  output  32, and cpu_stall  output  1: CPU read data; CPU must hold its request.
REQ-008 SHALL have ports dma_req/dma_write  input  1/1  DMA request, write qualifier.
REQ-009 SHALL have ports dma_wmask/dma_wdata/dma_addr  input  4/32/14  DMA byte mask, data, word address.
REQ-010 SHALL have ports dma_ack/dma_rvalid  output  1/1  DMA grant; DMA read data valid.
REQ-011 SHALL have port dma_rdata  output  32  DMA read data.
REQ-012 SHALL have ports ram_write/ram_wmask/ram_wdata/ram_addr  output  1/4/32/14  to both SPRAM halves.
REQ-013 SHALL have ports ram_rdata  input  32, and ram_standby  output  1  SPRAM STANDBY pin.

Function
REQ-014 SHALL implement states ACTIVE, FORCE, STANDBY, WAKE.
REQ-015 ACTIVE: cpu_valid grants CPU; else dma_req grants DMA, dma_ack=1 combinationally that cycle.
REQ-016 Grant SHALL drive ram_* combinationally from granted port; no grant: ram_write=0, ram_wmask=0, ram_addr/ram_wdata hold DMA port values.
REQ-017 ram_write SHALL equal the granted write qualifier; ram_wmask SHALL be 0 when ram_write=0.
REQ-018 cpu_rdata and dma_rdata SHALL both pass ram_rdata through; read latency one cycle after grant.
REQ-019 dma_rvalid SHALL be registered: 1 exactly one cycle after dma_ack with dma_write=0.
REQ-020 wait counter SHALL increment (saturating) each cycle dma_req=1 and dma_ack=0; clear on dma_ack or dma_req=0.
REQ-021 Counter reaching MAX_WAIT in ACTIVE SHALL move to FORCE next cycle.
REQ-022 FORCE: cpu_stall=1, CPU ignored, DMA granted if dma_req; next state ACTIVE (one cycle); dma_req dropped -> ACTIVE, no grant.
REQ-023 idle counter SHALL count consecutive ACTIVE cycles with cpu_valid=0 and dma_req=0; clear otherwise.
REQ-024 idle counter reaching IDLE_CYCLES SHALL enter STANDBY next cycle; ram_standby=1 in STANDBY only.
REQ-025 STANDBY: no grants; any cpu_valid or dma_req SHALL assert cpu_stall (if cpu_valid) that cycle and move to WAKE.
REQ-026 WAKE: ram_standby=0, cpu_stall=cpu_valid, no grants; next state ACTIVE.
REQ-027 cpu_stall SHALL be 0 in ACTIVE; CPU grant never stalls.
REQ-028 Simultaneous cpu_valid and dma_req in ACTIVE with counter below MAX_WAIT: CPU wins, DMA waits.

Reset
REQ-029 rst SHALL force state ACTIVE, both counters 0, dma_rvalid 0, ram_standby 0; ram_write, ram_wmask, dma_ack, cpu_stall 0 while rst=1.
REQ-030 rst mid-transfer SHALL drop any pending grant; no SPRAM write occurs during rst.

Configuration
REQ-031 Macro SPRAM_STANDBY_EN defined: STANDBY/WAKE behaviour per REQ-023..026.
REQ-032 Macro SPRAM_STANDBY_EN undefined: no idle counter, STANDBY/WAKE unreachable, ram_standby tied 0.

Verification
REQ-033 DMA read addr 0x0010 alone, SPRAM word 0xDEADBEEF -> dma_ack cycle N, dma_rvalid and dma_rdata=0xDEADBEEF cycle N+1.
REQ-034 cpu_valid continuous, dma_req held -> 8 cycles unacked, FORCE at cycle 9: cpu_stall=1, dma_ack=1, then ACTIVE, cpu_stall=0.
REQ-035 Simultaneous CPU write 0x0004 mask 0011 and DMA write -> CPU granted; ram_wmask=0011; DMA ack next free cycle.
REQ-036 With SPRAM_STANDBY_EN, 64 idle cycles -> ram_standby=1; cpu_valid -> cpu_stall 2 cycles, grant on third.
REQ-037 rst during FORCE with dma_req=1 -> dma_ack=0, ram_write=0, state ACTIVE, counters 0 after release.
